// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq
// Sequencer between the I2C-side mailbox (register file port 2) and the SPI
// master register interface. It polls mailbox CTRL. When GO is seen, it
// fetches the SPI address and TX byte and programs the SPI master. It then
// polls the SPI BUSY bit, copies the RX byte back to the mailbox, and writes
// mailbox CTRL (0x00 on success, 0x80 on timeout).
//
// Ports:
//   i_ck, i_rstn        clock, asynchronous active-low reset
//   o_sram_*            mailbox access: csn low for one cycle, read data
//   i_sram_rdata        returned the following cycle
//   o_spi_adr/din       SPI master register address / write data
//   o_spi_wr/rd         one-cycle register strobes
//   i_spi_dout          SPI read data, valid the cycle after o_spi_rd
//   o_busy              high from GO detect until CTRL writeback completes
//   o_timeout           sticky abort flag, cleared by reset or next GO
module spi_xfer_seq #(
   parameter int DW       = 8,
   parameter int AW       = 4,
   parameter int POLL_DIV = 16,
   parameter int TIMEOUT  = 1024
) (
   input  logic          i_ck,
   input  logic          i_rstn,
   output logic [AW-1:0] o_sram_addr,
   output logic          o_sram_rw,
   output logic          o_sram_csn,
   output logic [DW-1:0] o_sram_wdata,
   input  logic [DW-1:0] i_sram_rdata,
   output logic [AW-1:0] o_spi_adr,
   output logic [DW-1:0] o_spi_din,
   output logic          o_spi_wr,
   output logic          o_spi_rd,
   input  logic [DW-1:0] i_spi_dout,
   output logic          o_busy,
   output logic          o_timeout
);

   localparam int PW = $clog2(POLL_DIV + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   // mailbox map
   localparam logic [AW-1:0] MB_ADDR = AW'(0);
   localparam logic [AW-1:0] MB_TXD  = AW'(1);
   localparam logic [AW-1:0] MB_CTRL = AW'(2);
   localparam logic [AW-1:0] MB_RXD  = AW'(3);
   // SPI master map
   localparam logic [AW-1:0] SPI_CTRL = AW'(0);
   localparam logic [AW-1:0] SPI_TX   = AW'(1);
   localparam logic [AW-1:0] SPI_ADDR = AW'(2);
   localparam logic [AW-1:0] SPI_RX   = AW'(3);

   localparam logic [DW-1:0] ERR_BYTE = DW'(1) << 7;

   typedef enum logic [3:0] {
      IDLE, RD_CTRL, RD_ADDR, RD_TXD, WR_SADDR, WR_STX, WR_SCTRL,
      POLL_SPI, RD_SRX, WR_RXD, WR_CTRL
   } state_t;

   state_t        state;
   logic          ph;        // 0: access cycle A, 1: cycle B (data returned)
   logic [PW-1:0] poll_cnt;
   logic [TW-1:0] to_cnt;
   logic [TW-1:0] to_cnt_nxt;
   logic [DW-1:0] ctrl_q;
   logic [DW-1:0] saddr_q;
   logic [DW-1:0] stx_q;

   assign to_cnt_nxt = to_cnt + TW'(1);

   // Each access is launched on the edge that leaves the previous state.
   // A state's cycle A therefore already shows the strobe. Cycle B returns
   // the data and launches the next access. This keeps mailbox accesses at
   // 2 cycles, with csn high in every cycle B.
   always_ff @(posedge i_ck or negedge i_rstn) begin
      if (!i_rstn) begin
         state        <= IDLE;
         ph           <= 1'b0;
         poll_cnt     <= '0;
         to_cnt       <= '0;
         ctrl_q       <= '0;
         saddr_q      <= '0;
         stx_q        <= '0;
         o_sram_addr  <= '0;
         o_sram_rw    <= 1'b1;
         o_sram_csn   <= 1'b1;
         o_sram_wdata <= '0;
         o_spi_adr    <= '0;
         o_spi_din    <= '0;
         o_spi_wr     <= 1'b0;
         o_spi_rd     <= 1'b0;
         o_busy       <= 1'b0;
         o_timeout    <= 1'b0;
      end else begin
         // strobes are single-cycle unless relaunched below
         o_sram_csn <= 1'b1;
         o_sram_rw  <= 1'b1;
         o_spi_wr   <= 1'b0;
         o_spi_rd   <= 1'b0;

         case (state)
            IDLE: begin
               if (poll_cnt == PW'(POLL_DIV - 1)) begin
                  poll_cnt    <= '0;
                  o_sram_csn  <= 1'b0;
                  o_sram_addr <= MB_CTRL;
                  state       <= RD_CTRL;
               end else begin
                  poll_cnt <= poll_cnt + PW'(1);
               end
            end

            RD_CTRL: begin
               ph <= ~ph;
               if (ph) begin
                  if (i_sram_rdata[0]) begin
                     ctrl_q      <= i_sram_rdata;
                     o_busy      <= 1'b1;
                     o_timeout   <= 1'b0;
                     o_sram_csn  <= 1'b0;
                     o_sram_addr <= MB_ADDR;
                     state       <= RD_ADDR;
                  end else begin
                     state <= IDLE;
                  end
               end
            end

            RD_ADDR: begin
               ph <= ~ph;
               if (ph) begin
                  saddr_q     <= i_sram_rdata;
                  o_sram_csn  <= 1'b0;
                  o_sram_addr <= MB_TXD;
                  state       <= RD_TXD;
               end
            end

            RD_TXD: begin
               ph <= ~ph;
               if (ph) begin
                  stx_q     <= i_sram_rdata;
                  o_spi_wr  <= 1'b1;
                  o_spi_adr <= SPI_ADDR;
                  o_spi_din <= saddr_q;
                  state     <= WR_SADDR;
               end
            end

            WR_SADDR: begin
               o_spi_wr  <= 1'b1;
               o_spi_adr <= SPI_TX;
               o_spi_din <= stx_q;
               state     <= WR_STX;
            end

            WR_STX: begin
               // the latched ctrl byte carries bit0=1, which starts the SPI
               o_spi_wr  <= 1'b1;
               o_spi_adr <= SPI_CTRL;
               o_spi_din <= ctrl_q;
               state     <= WR_SCTRL;
            end

            WR_SCTRL: begin
               o_spi_rd  <= 1'b1;
               o_spi_adr <= SPI_CTRL;
               to_cnt    <= '0;
               state     <= POLL_SPI;
            end

            POLL_SPI: begin
               ph <= ~ph;
               if (ph) begin
                  if (!i_spi_dout[0]) begin
                     to_cnt    <= '0;
                     o_spi_rd  <= 1'b1;
                     o_spi_adr <= SPI_RX;
                     state     <= RD_SRX;
                  end else if (to_cnt_nxt == TW'(TIMEOUT)) begin
                     to_cnt       <= '0;
                     o_timeout    <= 1'b1;
                     o_sram_csn   <= 1'b0;
                     o_sram_rw    <= 1'b0;
                     o_sram_addr  <= MB_CTRL;
                     o_sram_wdata <= ERR_BYTE;
                     state        <= WR_CTRL;
                  end else begin
                     to_cnt   <= to_cnt_nxt;
                     o_spi_rd <= 1'b1;
                  end
               end
            end

            RD_SRX: begin
               ph <= ~ph;
               if (ph) begin
                  o_sram_csn   <= 1'b0;
                  o_sram_rw    <= 1'b0;
                  o_sram_addr  <= MB_RXD;
                  o_sram_wdata <= i_spi_dout;
                  state        <= WR_RXD;
               end
            end

            WR_RXD: begin
               ph <= ~ph;
               if (ph) begin
                  o_sram_csn   <= 1'b0;
                  o_sram_rw    <= 1'b0;
                  o_sram_addr  <= MB_CTRL;
                  o_sram_wdata <= '0;
                  state        <= WR_CTRL;
               end
            end

            WR_CTRL: begin
               ph <= ~ph;
               if (ph) begin
                  o_busy <= 1'b0;
                  state  <= IDLE;
               end
            end

            default: begin
               ph    <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
